// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the round-robin / fixed priority encoder.
package encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width that never collapses to zero, so N=2 still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// Request/result handshake bundle between request sources and the encoder.
interface rr_priority_encoder_if #(
  parameter int N = 8
);
  import encoder_pkg::*;

  localparam int W = clog2_min1(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_any;
  logic         out_multi;

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_any, out_multi
  );

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_any, out_multi
  );

endinterface

// File: rtl/prio_find.sv
// Combinational first-set search starting at an arbitrary position, either
// upward from start (wrapping) or from the top down.
module prio_find #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         msb_first,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  localparam int WP = W + 1;

  logic [N-1:0]  rot;
  logic [WP-1:0] off;
  logic [WP-1:0] sum;
  logic          hit;

  // rot[0] lines up with req[start]; upper half of the double word supplies the wrap.
  assign rot = N'({req, req} >> start);

  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && rot[msb_first ? (N - 1 - i) : i]) begin
        hit = 1'b1;
        off = WP'(msb_first ? (N - 1 - i) : i);
      end
    end
  end

  // start + off < 2N, so a single conditional subtract is a full mod N.
  assign sum    = WP'(start) + off;
  assign any    = |req;
  assign idx    = !any ? '0 : (sum >= WP'(N)) ? W'(sum - WP'(N)) : W'(sum);
  assign onehot = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rr_priority_encoder.sv
// N-to-log2(N) priority encoder, fixed (MSB wins) or round-robin, with a
// single registered result stage behind a valid/ready handshake.
module rr_priority_encoder
  import encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_priority_encoder_if.slave bus
);

  localparam int W = clog2_min1(N);

  logic         in_ready;
  logic         accept;
  logic         req_multi;
  logic [W-1:0] start;
  logic [W-1:0] f_idx;
  logic [N-1:0] f_oh;
  logic         f_any;

  logic         vld_q,   vld_d;
  logic [W-1:0] idx_q,   idx_d;
  logic [N-1:0] oh_q,    oh_d;
  logic         any_q,   any_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q,   ptr_d;

  assign in_ready  = !vld_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign req_multi = |(bus.in_req & (bus.in_req - N'(1)));
  assign start     = (MODE == MODE_RR) ? ptr_q : '0;

  prio_find #(
    .N (N),
    .W (W)
  ) u_find (
    .req       (bus.in_req),
    .start     (start),
    .msb_first (MODE == MODE_FIXED),
    .idx       (f_idx),
    .onehot    (f_oh),
    .any       (f_any)
  );

  always_comb begin
    vld_d   = vld_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    any_d   = any_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (accept) begin
      vld_d   = 1'b1;
      idx_d   = f_idx;
      oh_d    = f_oh;
      any_d   = f_any;
      multi_d = req_multi;
      if (MODE == MODE_RR && f_any)
        ptr_d = (f_idx == W'(N - 1)) ? '0 : f_idx + W'(1);
    end else if (bus.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      any_q   <= 1'b0;
      multi_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      any_q   <= any_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = vld_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = oh_q;
  assign bus.out_any    = any_q;
  assign bus.out_multi  = multi_q;

endmodule
